state_sequencer: RTL

- Generates the 4-bit state code driven into the state-code decoder stage.
- Steps the code through the range MIN_CODE..MAX_CODE (default 1..9). One step is taken every CLK_DIV clocks while running.
- Supports up/down direction, start/stop, and a synchronous load of an arbitrary in-range code.
- The decoder's register follows this block's output one clock later.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/seq_prescaler.sv | 38 +++
 rtl/state_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the state-code sequencer feeding the state-code decoder.
package seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // State codes as seen by the decoder (letters b..j)
  localparam logic [3:0] CODE_B = 4'b0001;
  localparam logic [3:0] CODE_C = 4'b0010;
  localparam logic [3:0] CODE_D = 4'b0011;
  localparam logic [3:0] CODE_E = 4'b0100;
  localparam logic [3:0] CODE_F = 4'b0101;
  localparam logic [3:0] CODE_G = 4'b0110;
  localparam logic [3:0] CODE_H = 4'b0111;
  localparam logic [3:0] CODE_I = 4'b1000;
  localparam logic [3:0] CODE_J = 4'b1001;

  localparam logic [3:0] DEF_MIN_CODE = CODE_B;
  localparam logic [3:0] DEF_MAX_CODE = CODE_J;

  function automatic logic code_in_range(input logic [3:0] code,
                                         input logic [3:0] lo,
                                         input logic [3:0] hi);
    return (code >= lo) && (code <= hi);
  endfunction

endpackage

// File: rtl/seq_prescaler.sv
// Divide-by-CLK_DIV step prescaler; tc marks the clock whose edge takes a step.
module seq_prescaler #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q, count_d;
  logic          at_last;

  assign at_last = (count_q == LAST);
  assign tc      = enable && at_last;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = at_last ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/state_sequencer.sv
// Steps a 4-bit state code through MIN_CODE..MAX_CODE with start/stop, direction and load.
// Define SEQ_ONESHOT_EN to stop at the end code (pulsing done_o) instead of wrapping.
module state_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [3:0]  MIN_CODE = DEF_MIN_CODE,
  parameter logic [3:0]  MAX_CODE = DEF_MAX_CODE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_code,
  output logic [3:0] statein_o,
  output logic       step_o,
  output logic       busy_o,
  output logic       load_err_o,
  output logic       done_o
);

  seq_state_e state_q, state_d;
  logic [3:0] code_q, code_d;
  logic       step_q, step_d;
  logic       load_err_q, load_err_d;
  logic       load_ok, load_hit;
  logic       running, tc, pre_clear;
  logic [3:0] next_code;
`ifdef SEQ_ONESHOT_EN
  logic       done_q, done_d;
  logic       at_end, finish;
`endif

  assign running  = (state_q == ST_RUN);
  assign load_ok  = code_in_range(load_code, MIN_CODE, MAX_CODE);
  assign load_hit = load && load_ok;

  always_comb begin
    if (dir) begin
      next_code = (code_q == MAX_CODE) ? MIN_CODE : code_q + 4'd1;
    end else begin
      next_code = (code_q == MIN_CODE) ? MAX_CODE : code_q - 4'd1;
    end
  end

`ifdef SEQ_ONESHOT_EN
  assign at_end = dir ? (code_q == MAX_CODE) : (code_q == MIN_CODE);
  assign finish = tc && at_end;
`endif

  seq_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (pre_clear),
    .enable (running),
    .tc     (tc)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; an accepted load freezes the state for that edge
  always_comb begin
    state_d = state_q;
    if (!load_hit) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_IDLE;
`ifdef SEQ_ONESHOT_EN
          end else if (finish) begin
            state_d = ST_IDLE;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy_o     = running;
    statein_o  = code_q;
    step_o     = step_q;
    load_err_o = load_err_q;
`ifdef SEQ_ONESHOT_EN
    done_o     = done_q;
`else
    done_o     = 1'b0;
`endif
  end

  // Code register next value; priority is load > stop > start > step.
  // A rejected load only raises load_err and does not disturb anything else.
  always_comb begin
    code_d     = code_q;
    step_d     = 1'b0;
    load_err_d = load && !load_ok;
    pre_clear  = !running;
`ifdef SEQ_ONESHOT_EN
    done_d     = 1'b0;
`endif
    if (load_hit) begin
      code_d    = load_code;
      pre_clear = 1'b1;
    end else if (stop) begin
      pre_clear = 1'b1;
    end else if (start && !running) begin
      pre_clear = 1'b1;
    end else if (tc) begin
`ifdef SEQ_ONESHOT_EN
      if (at_end) begin
        done_d = 1'b1;
      end else begin
        code_d = next_code;
        step_d = 1'b1;
      end
`else
      code_d = next_code;
      step_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q     <= MIN_CODE;
      step_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      code_q     <= code_d;
      step_q     <= step_d;
      load_err_q <= load_err_d;
    end
  end

`ifdef SEQ_ONESHOT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end
`endif

`ifndef SYNTHESIS
  code_in_range_a : assert property (
    @(posedge clk) disable iff (reset) code_in_range(code_q, MIN_CODE, MAX_CODE)
  );
`endif

endmodule
